// File: rtl/controlador_requisicoes_pkg.sv
// Shared definitions for the path-request controller: defaults, derived widths, FSM states.
package controlador_requisicoes_pkg;

    localparam int unsigned ADDR_WIDTH_PADRAO    = 10;
    localparam int unsigned FILA_DEPTH_PADRAO    = 4;
    localparam int unsigned MAX_PASSOS_PADRAO    = 64;
    localparam int unsigned TIMEOUT_WIDTH_PADRAO = 16;

    localparam int unsigned NIVEL_WIDTH  = $clog2(FILA_DEPTH_PADRAO + 1);
    localparam int unsigned PASSOS_WIDTH = $clog2(MAX_PASSOS_PADRAO + 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIAR  = 3'd1,
        BUSCANDO = 3'd2,
        EMITIR   = 3'd3,
        LER      = 3'd4,
        ESPERA   = 3'd5
    } estado_t;

endpackage

// File: rtl/controlador_requisicoes_caminho_fila.sv
// Synchronous request FIFO with registered level and registered not-full flag.
module fila_requisicoes #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             dados_in,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dados_c,
    output logic                         vazia_c,
    output logic                         pronto,
    output logic [$clog2(DEPTH+1)-1:0]   nivel
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned NIVEL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [NIVEL_W-1:0] nivel_prox;
    logic               escrever;
    logic               ler;

    assign vazia_c  = (nivel == '0);
    assign escrever = push && pronto;
    assign ler      = pop && !vazia_c;
    assign dados_c  = mem[rd_ptr];

    always_comb begin
        nivel_prox = nivel;
        if (escrever && !ler) begin
            nivel_prox = nivel + NIVEL_W'(1);
        end else if (ler && !escrever) begin
            nivel_prox = nivel - NIVEL_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            nivel  <= '0;
            pronto <= 1'b1;
        end else begin
            if (escrever) wr_ptr <= wr_ptr + PTR_W'(1);
            if (ler)      rd_ptr <= rd_ptr + PTR_W'(1);
            nivel  <= nivel_prox;
            pronto <= (nivel_prox != NIVEL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (escrever) mem[wr_ptr] <= dados_in;
    end

endmodule

// File: rtl/controlador_requisicoes_caminho.sv
// Queues (fonte, destino) requests, runs one search at a time and streams the path
// back from destino to fonte over valid/ready, with timeout and walk-length limits.
module controlador_requisicoes_caminho
    import controlador_requisicoes_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_PADRAO,
    parameter int unsigned FILA_DEPTH    = FILA_DEPTH_PADRAO,
    parameter int unsigned MAX_PASSOS    = MAX_PASSOS_PADRAO,
    parameter int unsigned TIMEOUT_WIDTH = TIMEOUT_WIDTH_PADRAO
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid_in,
    output logic                              req_ready_out,
    input  logic [ADDR_WIDTH-1:0]             req_fonte_in,
    input  logic [ADDR_WIDTH-1:0]             req_destino_in,
    input  logic [TIMEOUT_WIDTH-1:0]          timeout_limite_in,
    output logic                              busca_iniciar_out,
    output logic [ADDR_WIDTH-1:0]             busca_fonte_out,
    output logic [ADDR_WIDTH-1:0]             busca_destino_out,
    input  logic                              busca_pronto_in,
    output logic                              anterior_rd_en_out,
    output logic [ADDR_WIDTH-1:0]             anterior_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0]             anterior_rd_data_in,
    output logic                              caminho_valid_out,
    input  logic                              caminho_ready_in,
    output logic [ADDR_WIDTH-1:0]             caminho_addr_out,
    output logic                              caminho_ultimo_out,
    output logic                              caminho_erro_out,
    output logic                              ocupado_out,
    output logic [$clog2(FILA_DEPTH+1)-1:0]   fila_nivel_out
);
    localparam int unsigned PASSOS_W = $clog2(MAX_PASSOS + 1);

    estado_t                   estado, estado_prox;
    logic [PASSOS_W-1:0]       passos, passos_prox;
    logic [TIMEOUT_WIDTH-1:0]  contador, contador_prox;
    logic [ADDR_WIDTH-1:0]     fonte_prox, destino_prox;
    logic [ADDR_WIDTH-1:0]     rd_addr_prox, addr_prox;
    logic                      iniciar_prox, rd_en_prox, valid_prox, ultimo_prox, erro_prox;
    logic                      erro_passos;
    logic                      pop_c;
    logic                      fila_vazia_c;
    logic [2*ADDR_WIDTH-1:0]   fila_dados_c;

    fila_requisicoes #(
        .WIDTH (2 * ADDR_WIDTH),
        .DEPTH (FILA_DEPTH)
    ) u_fila (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_valid_in),
        .dados_in ({req_fonte_in, req_destino_in}),
        .pop      (pop_c),
        .dados_c  (fila_dados_c),
        .vazia_c  (fila_vazia_c),
        .pronto   (req_ready_out),
        .nivel    (fila_nivel_out)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        estado_prox   = estado;
        passos_prox   = passos;
        contador_prox = contador;
        fonte_prox    = busca_fonte_out;
        destino_prox  = busca_destino_out;
        rd_addr_prox  = anterior_rd_addr_out;
        addr_prox     = caminho_addr_out;
        iniciar_prox  = 1'b0;
        rd_en_prox    = 1'b0;
        valid_prox    = 1'b0;
        ultimo_prox   = 1'b0;
        erro_prox     = 1'b0;
        erro_passos   = 1'b0;
        pop_c         = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!fila_vazia_c) begin
                    pop_c                      = 1'b1;
                    {fonte_prox, destino_prox} = fila_dados_c;
                    iniciar_prox               = 1'b1;
                    estado_prox                = INICIAR;
                end
            end
            INICIAR: begin
                contador_prox = '0;
                estado_prox   = BUSCANDO;
            end
            BUSCANDO: begin
                contador_prox = contador + TIMEOUT_WIDTH'(1);
                if (busca_pronto_in) begin
                    passos_prox = '0;
                    valid_prox  = 1'b1;
                    addr_prox   = busca_destino_out;
                    ultimo_prox = (busca_destino_out == busca_fonte_out);
                    estado_prox = EMITIR;
                end else if ((timeout_limite_in != '0) &&
                             (contador == timeout_limite_in - TIMEOUT_WIDTH'(1))) begin
                    valid_prox  = 1'b1;
                    addr_prox   = busca_destino_out;
                    ultimo_prox = 1'b1;
                    erro_prox   = 1'b1;
                    estado_prox = EMITIR;
                end
            end
            EMITIR: begin
                if (caminho_ready_in) begin
                    if (caminho_ultimo_out) begin
                        estado_prox = OCIOSO;
                    end else begin
                        passos_prox  = passos + PASSOS_W'(1);
                        rd_en_prox   = 1'b1;
                        rd_addr_prox = caminho_addr_out;
                        estado_prox  = LER;
                    end
                end else begin
                    valid_prox  = 1'b1;
                    ultimo_prox = caminho_ultimo_out;
                    erro_prox   = caminho_erro_out;
                end
            end
            LER: begin
                estado_prox = ESPERA;
            end
            ESPERA: begin
                // The walk is cut on the beat that would exceed MAX_PASSOS.
                erro_passos = (passos == PASSOS_W'(MAX_PASSOS - 1));
                valid_prox  = 1'b1;
                addr_prox   = anterior_rd_data_in;
                erro_prox   = erro_passos;
                ultimo_prox = (anterior_rd_data_in == busca_fonte_out) || erro_passos;
                estado_prox = EMITIR;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado               <= OCIOSO;
            passos               <= '0;
            contador             <= '0;
            busca_fonte_out      <= '0;
            busca_destino_out    <= '0;
            busca_iniciar_out    <= 1'b0;
            anterior_rd_en_out   <= 1'b0;
            anterior_rd_addr_out <= '0;
            caminho_valid_out    <= 1'b0;
            caminho_addr_out     <= '0;
            caminho_ultimo_out   <= 1'b0;
            caminho_erro_out     <= 1'b0;
            ocupado_out          <= 1'b0;
        end else begin
            estado               <= estado_prox;
            passos               <= passos_prox;
            contador             <= contador_prox;
            busca_fonte_out      <= fonte_prox;
            busca_destino_out    <= destino_prox;
            busca_iniciar_out    <= iniciar_prox;
            anterior_rd_en_out   <= rd_en_prox;
            anterior_rd_addr_out <= rd_addr_prox;
            caminho_valid_out    <= valid_prox;
            caminho_addr_out     <= addr_prox;
            caminho_ultimo_out   <= ultimo_prox;
            caminho_erro_out     <= erro_prox;
            ocupado_out          <= (estado_prox != OCIOSO);
        end
    end

endmodule

// File: doc/controlador_requisicoes_caminho.md
Name: controlador_requisicoes_caminho

Overview:
Front-end controller for the path-search engine. It queues (fonte, destino) requests and launches one search at a time. After the search finishes, it walks the anterior memory from destino back to fonte and streams the path out over a valid/ready interface. It adds a request FIFO, a search timeout, a bounded path walk and error reporting to the current single-request top-level control.

Parameters:
ADDR_WIDTH, 10, node address width
FILA_DEPTH, 4, request FIFO depth (power of 2, >=2)
MAX_PASSOS, 64, maximum path beats before the walk is aborted
TIMEOUT_WIDTH, 16, width of the search-cycle counter and limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_in  in  1  request offered
req_ready_out  out  1  FIFO not full
req_fonte_in  in  ADDR_WIDTH  source node
req_destino_in  in  ADDR_WIDTH  destination node
timeout_limite_in  in  TIMEOUT_WIDTH  search cycle limit; 0 disables the timeout
busca_iniciar_out  out  1  one-cycle search start pulse
busca_fonte_out  out  ADDR_WIDTH  active source, stable while the search runs
busca_destino_out  out  ADDR_WIDTH  active destination, stable while the search runs
busca_pronto_in  in  1  search-complete pulse (cme caminho pronto)
anterior_rd_en_out  out  1  anterior memory read strobe
anterior_rd_addr_out  out  ADDR_WIDTH  anterior read address
anterior_rd_data_in  in  ADDR_WIDTH  anterior read data, valid 1 cycle after the strobe
caminho_valid_out  out  1  path beat valid
caminho_ready_in  in  1  consumer accepts beat
caminho_addr_out  out  ADDR_WIDTH  path node
caminho_ultimo_out  out  1  last beat of the path
caminho_erro_out  out  1  beat reports a timeout or overlong path
ocupado_out  out  1  FSM not in OCIOSO
fila_nivel_out  out  $clog2(FILA_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. On reset:
  - all outputs go to 0 except req_ready_out, which is 1;
  - the FIFO is emptied, the FSM returns to OCIOSO, and all counters clear.
  - Reset mid-walk or mid-search aborts with no further beats emitted.
- FIFO:
  - Push when req_valid_in && req_ready_out; req_ready_out = !full.
  - Pop only in OCIOSO when not empty. A push and a pop in the same cycle are both allowed.
  - fila_nivel_out is updated on the cycle after each push or pop.
- FSM states: OCIOSO, INICIAR, BUSCANDO, EMITIR, LER, ESPERA.
- OCIOSO: if the FIFO is non-empty, pop it into the fonte/destino registers -> INICIAR.
- INICIAR: busca_iniciar_out=1 for exactly this one cycle; clear the timeout counter -> BUSCANDO.
- BUSCANDO:
  - The counter increments every cycle.
  - busca_pronto_in=1 -> EMITIR with cur=destino, passos=0, erro=0. busca_pronto_in has priority over the timeout in the same cycle.
  - Else if timeout_limite_in != 0 and counter == timeout_limite_in-1 -> EMITIR with cur=destino, erro=1, ultimo=1.
- EMITIR:
  - caminho_valid_out=1; caminho_addr_out=cur.
  - caminho_ultimo_out = (cur==fonte) || erro.
  - Outputs are held stable until caminho_ready_in. No combinational path from ready to valid.
  - On a handshake with ultimo: -> OCIOSO.
  - On a handshake otherwise: passos++ -> LER.
- LER: anterior_rd_en_out=1, anterior_rd_addr_out=cur -> ESPERA.
- ESPERA:
  - cur <= anterior_rd_data_in.
  - If passos == MAX_PASSOS-1, set erro=1 (forcing ultimo) on the next beat.
  - -> EMITIR.
- Path order is destino first, fonte last. Every step costs 3 cycles when ready is held high.
- fonte==destino: exactly one beat, addr=destino, ultimo=1, erro=0, no memory reads.
- Self-loop in anterior data (no fonte found): terminated by MAX_PASSOS, so at most MAX_PASSOS beats are emitted, the last one with erro=1.
- busca_pronto_in outside BUSCANDO is ignored.
- ocupado_out = (state != OCIOSO).
- Latency from the pop (a request in an empty FIFO is popped in the cycle after its push) to busca_iniciar_out: 1 cycle.

Decomposition:
- Package controlador_requisicoes_pkg holds:
  - the FSM state encoding (localparams);
  - the derived width NIVEL_WIDTH = $clog2(FILA_DEPTH+1);
  - PASSOS_WIDTH = $clog2(MAX_PASSOS+1).
- One sub-module, fila_requisicoes: a synchronous FIFO of width 2*ADDR_WIDTH and depth FILA_DEPTH, with a level output.
- The FSM, counters and walk logic stay in the parent.

Test Plan:
1. Push (fonte=5, destino=9) with anterior[9]=7, [7]=6, [6]=5; pulse busca_pronto after 10 cycles -> beats 9, 7, 6, 5; ultimo only on 5; erro=0; exactly 3 reads at addresses 9, 7, 6.
2. fonte=destino=12 -> a single beat 12 with ultimo=1, erro=0; anterior_rd_en_out never asserted.
3. timeout_limite_in=20, busca_pronto never pulsed -> after 20 BUSCANDO cycles, one beat addr=destino, ultimo=1, erro=1; FSM returns to OCIOSO.
4. MAX_PASSOS=4, anterior[3]=3, fonte=0, destino=3 -> 4 beats of addr 3; the 4th has erro=1, ultimo=1.
5. Push 5 requests back-to-back with FILA_DEPTH=4 while a search is running -> req_ready_out=0 after the 4th; fila_nivel_out=4; all 4 accepted requests are served in order, each with one busca_iniciar pulse.
6. Hold caminho_ready_in=0 for 5 cycles mid-path, then assert async reset mid-walk -> addr/ultimo stay stable while stalled; after reset all outputs are 0, req_ready_out=1, and no further beats appear.
